// File: rtl/vga_hsync_decoder.sv
// Horizontal VGA timing checker: measures active/front/sync/back
// segments, recovers pixel column, tracks lock and sticky errors.
//
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   hsync, hblank      sampled timing strobes (hsync active-low)
//   err_clear          sync pulse clearing all error flags
//   pixel_x            active column index (0 outside active)
//   pixel_valid        high on each active cycle
//   line_start         pulse on first active cycle of a line
//   locked             LOCK_LINES consecutive conforming lines seen
//   err_active/front/sync/back  sticky segment-length errors
//   err_seq            sticky illegal edge order or timeout
module vga_hsync_decoder #(
  parameter int H_ACTIVE   = 320,
  parameter int H_FRONT    = 9,
  parameter int H_SYNC     = 48,
  parameter int H_BACK     = 24,
  parameter int LOCK_LINES = 2,
  parameter int CW         = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          hsync,
  input  logic          hblank,
  input  logic          err_clear,
  output logic [CW-1:0] pixel_x,
  output logic          pixel_valid,
  output logic          line_start,
  output logic          locked,
  output logic          err_active,
  output logic          err_front,
  output logic          err_sync,
  output logic          err_back,
  output logic          err_seq
);

  typedef enum logic [2:0] {
    HUNT,
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } state_t;

  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] A_LEN = CW'(H_ACTIVE);
  localparam logic [CW-1:0] F_LEN = CW'(H_FRONT);
  localparam logic [CW-1:0] S_LEN = CW'(H_SYNC);
  localparam logic [CW-1:0] B_LEN = CW'(H_BACK);
  localparam logic [GW-1:0] G_MAX = GW'(LOCK_LINES);

  state_t        state;
  state_t        nxt;
  logic          hblank_q;
  logic          hsync_q;
  logic [CW-1:0] seg_cnt;
  logic [CW-1:0] seg_inc;
  logic [CW-1:0] seg_nxt;
  logic [GW-1:0] good_cnt;
  logic [GW-1:0] good_nxt;
  logic          line_bad;

  logic fall_b, rise_b, fall_s, rise_s;
  logic set_a, set_f, set_s, set_b, set_q;
  logic start, close, drop, any_set;

  assign fall_b = hblank_q & ~hblank;
  assign rise_b = ~hblank_q & hblank;
  assign fall_s = hsync_q & ~hsync;
  assign rise_s = ~hsync_q & hsync;

  always_comb begin
    nxt   = state;
    set_a = 1'b0;
    set_f = 1'b0;
    set_s = 1'b0;
    set_b = 1'b0;
    set_q = 1'b0;
    start = 1'b0;
    close = 1'b0;
    drop  = 1'b0;
    unique case (state)
      HUNT: begin
        if (fall_b) begin
          nxt   = ACTIVE;
          start = 1'b1;
        end
      end
      ACTIVE: begin
        if (fall_s | rise_s) begin
          nxt   = HUNT;
          set_q = 1'b1;
        end else if (rise_b) begin
          nxt   = FRONT;
          set_a = (seg_cnt != A_LEN);
        end
      end
      FRONT: begin
        if (fall_s) begin
          nxt   = SYNC;
          set_f = (seg_cnt != F_LEN);
        end else if (fall_b) begin
          // blank ended with no sync pulse at all
          nxt   = ACTIVE;
          set_s = 1'b1;
          start = 1'b1;
          drop  = 1'b1;
        end
      end
      SYNC: begin
        if (rise_b | fall_b) begin
          nxt   = HUNT;
          set_q = 1'b1;
        end else if (rise_s) begin
          nxt   = BACK;
          set_s = (seg_cnt != S_LEN);
        end
      end
      BACK: begin
        if (fall_s) begin
          nxt   = HUNT;
          set_q = 1'b1;
        end else if (fall_b) begin
          nxt   = ACTIVE;
          set_b = (seg_cnt != B_LEN);
          start = 1'b1;
          close = 1'b1;
        end
      end
      default: nxt = HUNT;
    endcase
    // a segment that never ends is a lost signal
    if (state != HUNT && nxt == state && seg_cnt == CNT_MAX) begin
      nxt   = HUNT;
      set_q = 1'b1;
    end
  end

  assign any_set = set_a | set_f | set_s | set_b | set_q;
  assign seg_inc = (seg_cnt == CNT_MAX) ? seg_cnt : seg_cnt + 1'b1;
  assign seg_nxt = (nxt != state) ? CW'(1) : seg_inc;

  always_comb begin
    good_nxt = good_cnt;
    if (drop || (nxt == HUNT && state != HUNT)) begin
      good_nxt = '0;
    end else if (close) begin
      if (line_bad | any_set) good_nxt = '0;
      else if (good_cnt != G_MAX) good_nxt = good_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      hblank_q    <= 1'b0;
      hsync_q     <= 1'b1;
      seg_cnt     <= '0;
      good_cnt    <= '0;
      line_bad    <= 1'b0;
      pixel_x     <= '0;
      pixel_valid <= 1'b0;
      line_start  <= 1'b0;
      locked      <= 1'b0;
      err_active  <= 1'b0;
      err_front   <= 1'b0;
      err_sync    <= 1'b0;
      err_back    <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      state       <= nxt;
      hblank_q    <= hblank;
      hsync_q     <= hsync;
      seg_cnt     <= seg_nxt;
      good_cnt    <= good_nxt;
      // flags raised on the starting edge belong to the previous line
      line_bad    <= start ? 1'b0 : (line_bad | any_set);
      pixel_valid <= (nxt == ACTIVE);
      pixel_x     <= (nxt == ACTIVE) ? seg_nxt - 1'b1 : '0;
      line_start  <= start;
      locked      <= (good_nxt == G_MAX);
      err_active  <= set_a | (err_active & ~err_clear);
      err_front   <= set_f | (err_front & ~err_clear);
      err_sync    <= set_s | (err_sync & ~err_clear);
      err_back    <= set_b | (err_back & ~err_clear);
      err_seq     <= set_q | (err_seq & ~err_clear);
    end
  end

endmodule
